// File: rtl/plab4_net_router_output_ctrl_sep_pkg.sv
// rtl/plab4_net_router_output_ctrl_sep_pkg.sv - shared constants for the router output-port controller
package plab4_net_router_output_ctrl_sep_pkg;

  // Crossbar select value driven when no input port owns the output
  localparam logic [1:0] XBAR_SEL_IDLE = 2'd3;

  // Input-port indices as seen by the crossbar
  localparam logic [1:0] PORT_P0 = 2'd0;
  localparam logic [1:0] PORT_P1 = 2'd1;
  localparam logic [1:0] PORT_P2 = 2'd2;

  // Security domains sharing the port in TDM mode
  localparam logic DOM_NORMAL = 1'b0;
  localparam logic DOM_SECURE = 1'b1;

  // Round-robin pointer after reset: port 0 first
  localparam logic [2:0] PRIO_RESET = 3'b001;

  // The port after the winner becomes highest priority
  function automatic logic [2:0] rotl3(input logic [2:0] v);
    return {v[1:0], v[2]};
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_sep_rr_arbiter3.sv
// rtl/plab4_net_router_output_ctrl_sep_rr_arbiter3.sv - combinational 3-way round-robin pick
module plab4_net_rr_arbiter3
  import plab4_net_router_output_ctrl_sep_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [2:0] prio,
  output logic [2:0] grant,
  output logic [1:0] idx
);

  logic [1:0] order [3];
  logic       found;

  // Scan eligible ports circularly starting at the one-hot priority pointer
  always_comb begin
    grant = 3'b000;
    idx   = XBAR_SEL_IDLE;
    found = 1'b0;
    case (prio)
      3'b010: begin
        order[0] = PORT_P1;
        order[1] = PORT_P2;
        order[2] = PORT_P0;
      end
      3'b100: begin
        order[0] = PORT_P2;
        order[1] = PORT_P0;
        order[2] = PORT_P1;
      end
      default: begin
        order[0] = PORT_P0;
        order[1] = PORT_P1;
        order[2] = PORT_P2;
      end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!found && elig[order[k]]) begin
        found           = 1'b1;
        grant[order[k]] = 1'b1;
        idx             = order[k];
      end
    end
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl_sep.sv
// rtl/plab4_net_router_output_ctrl_sep.sv - per-output-port arbiter with optional TDM domain slots
module plab4_net_router_output_ctrl_sep
  import plab4_net_router_output_ctrl_sep_pkg::*;
#(
  parameter  int p_slot_cycles  = 8,
  parameter  int p_guard_cycles = 1,
  localparam int c_cnt_nbits    = $clog2(p_slot_cycles)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tdm_en,
  input  logic                   reqs_p0,
  input  logic                   reqs_p1,
  input  logic                   reqs_p2,
  input  logic                   req_domain_p0,
  input  logic                   req_domain_p1,
  input  logic                   req_domain_p2,
  input  logic                   out_rdy,
  output logic                   grants_p0,
  output logic                   grants_p1,
  output logic                   grants_p2,
  output logic                   out_val,
  output logic [1:0]             xbar_sel,
  output logic                   slot_domain,
  output logic [c_cnt_nbits-1:0] slot_cnt
);

  localparam logic [c_cnt_nbits-1:0] c_cnt_last    = c_cnt_nbits'(p_slot_cycles - 1);
  localparam logic [c_cnt_nbits-1:0] c_guard_start = c_cnt_nbits'(p_slot_cycles - p_guard_cycles);
  localparam logic                   c_has_guard   = (p_guard_cycles != 0);

  logic [2:0]             prio_q, prio_d;
  logic [c_cnt_nbits-1:0] slot_cnt_q, slot_cnt_d;
  logic                   slot_domain_q, slot_domain_d;

  logic [2:0] reqs;
  logic [2:0] doms;
  logic       guard;
  logic [2:0] elig;
  logic [2:0] arb_grant;
  logic [1:0] arb_idx;
  logic [2:0] grants;
  logic       val;

  assign reqs = {reqs_p2, reqs_p1, reqs_p0};
  assign doms = {req_domain_p2, req_domain_p1, req_domain_p0};

  // Eligibility: domain filter and end-of-slot guard apply only in TDM mode
  always_comb begin
    guard = tdm_en & c_has_guard & (slot_cnt_q >= c_guard_start);
    elig  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      elig[i] = reqs[i] & (!tdm_en | (doms[i] == slot_domain_q)) & !guard & out_rdy;
    end
  end

  plab4_net_rr_arbiter3 u_arb (
    .elig  (elig),
    .prio  (prio_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Grants are masked during reset so a held reset never leaks a grant
  always_comb begin
    grants   = reset ? arb_grant : 3'b000;
    xbar_sel = reset ? arb_idx : XBAR_SEL_IDLE;
    val      = |grants;
  end

  // Next priority pointer and slot counter/domain
  always_comb begin
    prio_d        = val ? rotl3(grants) : prio_q;
    slot_cnt_d    = slot_cnt_q;
    slot_domain_d = slot_domain_q;
    if (!tdm_en) begin
      slot_cnt_d    = '0;
      slot_domain_d = DOM_NORMAL;
    end else if (slot_cnt_q == c_cnt_last) begin
      slot_cnt_d    = '0;
      slot_domain_d = (slot_domain_q == DOM_NORMAL) ? DOM_SECURE : DOM_NORMAL;
    end else begin
      slot_cnt_d    = slot_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q        <= PRIO_RESET;
      slot_cnt_q    <= '0;
      slot_domain_q <= DOM_NORMAL;
    end else begin
      prio_q        <= prio_d;
      slot_cnt_q    <= slot_cnt_d;
      slot_domain_q <= slot_domain_d;
    end
  end

  assign grants_p0   = grants[0];
  assign grants_p1   = grants[1];
  assign grants_p2   = grants[2];
  assign out_val     = val;
  assign slot_domain = slot_domain_q & tdm_en;
  assign slot_cnt    = slot_cnt_q;

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_sep.sv
// tb/tb_plab4_net_router_output_ctrl_sep.sv - testbench for the router output-port controller
module tb_plab4_net_router_output_ctrl_sep;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tdm_en;
  logic [2:0] reqs;
  logic [2:0] doms;
  logic       out_rdy;
  logic       g0, g1, g2;
  logic       out_val;
  logic [1:0] xbar_sel;
  logic       slot_domain;
  logic [2:0] slot_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       tdm;
    logic [2:0] reqs;
    logic [2:0] doms;
    logic       rdy;
    logic [2:0] g;
    logic [1:0] sel;
    logic [2:0] cnt;
    logic       dom;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  plab4_net_router_output_ctrl_sep dut (
    .clk           (clk),
    .reset         (rst_n),
    .tdm_en        (tdm_en),
    .reqs_p0       (reqs[0]),
    .reqs_p1       (reqs[1]),
    .reqs_p2       (reqs[2]),
    .req_domain_p0 (doms[0]),
    .req_domain_p1 (doms[1]),
    .req_domain_p2 (doms[2]),
    .out_rdy       (out_rdy),
    .grants_p0     (g0),
    .grants_p1     (g1),
    .grants_p2     (g2),
    .out_val       (out_val),
    .xbar_sel      (xbar_sel),
    .slot_domain   (slot_domain),
    .slot_cnt      (slot_cnt)
  );

  function automatic vec_t mk(logic tdm, logic [2:0] r, logic [2:0] d, logic rdy,
                              logic [2:0] g, logic [1:0] sel, logic [2:0] cnt, logic dom);
    vec_t v;
    v.tdm = tdm; v.reqs = r; v.doms = d; v.rdy = rdy;
    v.g = g; v.sel = sel; v.cnt = cnt; v.dom = dom;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    tdm_en  = v.tdm;
    reqs    = v.reqs;
    doms    = v.doms;
    out_rdy = v.rdy;
    sb.push_back(v);
  endtask

  task automatic compare(int idx);
    vec_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 expected=1", idx);
    end else begin
      e = sb.pop_front();
      chk("grants",      idx, {5'd0, g2, g1, g0}, {5'd0, e.g});
      chk("out_val",     idx, {7'd0, out_val},    {7'd0, |e.g});
      chk("xbar_sel",    idx, {6'd0, xbar_sel},   {6'd0, e.sel});
      chk("slot_cnt",    idx, {5'd0, slot_cnt},   {5'd0, e.cnt});
      chk("slot_domain", idx, {7'd0, slot_domain}, {7'd0, e.dom});
    end
  endtask

  initial begin
    logic [2:0] g;
    logic [1:0] s;
    rst_n   = 1'b0;
    tdm_en  = 1'b0;
    reqs    = 3'b000;
    doms    = 3'b000;
    out_rdy = 1'b1;

    // idle after reset
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 3'b000, 2'd3, 3'd0, 0));
    // strict rotation with all requesting
    for (int k = 0; k < 6; k++) begin
      g = 3'b001 << (k % 3);
      s = 2'(k % 3);
      tbl.push_back(mk(0, 3'b111, 3'b000, 1, g, s, 3'd0, 0));
    end
    // out_rdy low blocks grants, first ready cycle grants p1
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 3'b010, 3'b000, 0, 3'b000, 2'd3, 3'd0, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 1, 3'b010, 2'd1, 3'd0, 0));
    // pointer moved to p2
    tbl.push_back(mk(0, 3'b111, 3'b000, 1, 3'b100, 2'd2, 3'd0, 0));
    // TDM: p0 domain 0, p2 domain 1
    for (int c = 0; c < 16; c++) begin
      if (c % 8 == 7) begin g = 3'b000; s = 2'd3; end
      else if (c < 8) begin g = 3'b001; s = 2'd0; end
      else begin g = 3'b100; s = 2'd2; end
      tbl.push_back(mk(1, 3'b101, 3'b100, 1, g, s, 3'(c % 8), 1'(c / 8)));
    end
    // TDM: p1 domain 1 starts requesting at slot_cnt=3 of domain 0
    for (int c = 16; c < 30; c++) begin
      if (c >= 24) begin g = 3'b010; s = 2'd1; end
      else begin g = 3'b000; s = 2'd3; end
      tbl.push_back(mk(1, (c < 19) ? 3'b000 : 3'b010, 3'b010, 1, g, s, 3'(c % 8), 1'((c / 8) % 2)));
    end

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      #2 compare(i);
    end

    // async reset mid-cycle while p1 holds a grant at slot_cnt=5 of domain 1
    #1 rst_n = 1'b0;
    #1 drive(mk(1, 3'b010, 3'b010, 1, 3'b000, 2'd3, 3'd0, 0));
    compare(100);
    #1 drive(mk(0, 3'b111, 3'b000, 1, 3'b000, 2'd3, 3'd0, 0));
    #1 compare(101);
    #1 rst_n = 1'b1;
    sb.push_back(mk(0, 3'b111, 3'b000, 1, 3'b001, 2'd0, 3'd0, 0));
    #1 compare(102);
    @(posedge clk);
    #1 drive(mk(0, 3'b111, 3'b000, 1, 3'b010, 2'd1, 3'd0, 0));
    #2 compare(103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_output_ctrl_sep.md
Name: plab4_net_router_output_ctrl_sep

Overview:
- Per-output-port controller for the router; one instance per output port (west, terminal, east).
- Arbitrates the three input-terminal request lines for this port and drives the matching grants back to the input controllers.
- Drives the crossbar select and output valid for the port.
- Optional time-division (TDM) mode alternates slots between security domain 0 and domain 1, so each domain sees port timing independent of the other.

Parameters:
p_slot_cycles, 8, cycles per TDM slot (must be >= 2)
p_guard_cycles, 1, cycles at end of each slot where no grant is issued (must be < p_slot_cycles)
c_cnt_nbits, $clog2(p_slot_cycles), slot counter width (derived, not set externally)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-low
tdm_en  input  1  1 = time-division domain partitioning enabled
reqs_p0  input  1  request from input port 0
reqs_p1  input  1  request from input port 1
reqs_p2  input  1  request from input port 2
req_domain_p0  input  1  security domain of port-0 request
req_domain_p1  input  1  security domain of port-1 request
req_domain_p2  input  1  security domain of port-2 request
out_rdy  input  1  downstream can accept a flit this cycle
grants_p0  output  1  grant to input port 0
grants_p1  output  1  grant to input port 1
grants_p2  output  1  grant to input port 2
out_val  output  1  flit valid on the output port
xbar_sel  output  2  crossbar select: 0/1/2 = granted port; 3 = idle
slot_domain  output  1  domain currently owning the port (0 when tdm_en=0)
slot_cnt  output  c_cnt_nbits  cycle index within the current slot

Behaviour:
- Reset (async, reset=0) forces:
  - prio = 3'b001, slot_cnt = 0, slot_domain = 0.
  - Outputs: grants = 0, out_val = 0, xbar_sel = 3.
  - Asserting reset mid-transfer drops any grant immediately; there is no partial state.
- Eligibility: elig[i] = reqs_pi & (!tdm_en | (req_domain_pi == slot_domain)) & !guard.
  - guard = tdm_en & (slot_cnt >= p_slot_cycles - p_guard_cycles).
- Grant, combinational with zero latency:
  - If out_rdy = 0, all grants are 0.
  - Otherwise, grant exactly one port: the first eligible port scanning circularly from the one-hot prio pointer (prio, then rotate-left of prio, and so on).
  - out_val = |grants.
  - xbar_sel = encoded index of the granted port, or 3 if no grant.
- Priority update:
  - On a clock edge where out_val = 1, prio <= rotate-left(grants). The port after the winner gets highest priority next cycle.
  - Otherwise prio holds.
- Slot counter:
  - While tdm_en = 1, slot_cnt increments each cycle.
  - At slot_cnt == p_slot_cycles-1, slot_cnt <= 0 and slot_domain toggles. This is the wrap.
  - While tdm_en = 0, slot_cnt <= 0 and slot_domain <= 0 on every edge.
- tdm_en transitions:
  - 0->1: the first TDM cycle has slot_cnt = 0 and domain 0.
  - 1->0: domain filtering stops that same cycle (combinational). Counter and domain clear on the next edge.
- Simultaneous events:
  - A grant on the last cycle of a slot is impossible because the guard is active.
  - The priority update and the slot wrap on the same edge are independent.
- All three requests active with tdm_en=0 and out_rdy held at 1: strict rotation 0,1,2,0,...
- Invariants:
  - grants is always one-hot or zero.
  - grants is never nonzero while out_rdy = 0.
  - With tdm_en=1, no grant is issued to a port whose req_domain differs from slot_domain.

Decomposition:
- Shared package/header `plab4-net-RouterCtrlDefs`:
  - XBAR_SEL_IDLE = 2'd3.
  - Port-index constants PORT_P0/P1/P2.
  - Domain constants DOM_NORMAL = 0, DOM_SECURE = 1.
- One sub-module, plab4_net_rr_arbiter3: combinational 3-way round-robin pick given elig and prio.
  - Returns one-hot grant and encoded index.
  - The pointer register stays in the parent so slot logic and priority state live together.

Test Plan:
- Reset release, no requests, out_rdy=1 -> grants=000, out_val=0, xbar_sel=3, slot_cnt=0.
- tdm_en=0, all three requesting, out_rdy=1 for 6 cycles -> grants 001,010,100,001,010,100; xbar_sel 0,1,2,0,1,2.
- reqs_p1 only, out_rdy=0 for 3 cycles then 1 -> no grant while out_rdy=0; grants=010 on first ready cycle; prio becomes 100 after that edge.
- tdm_en=1, defaults, p0 domain 0 and p2 domain 1 both requesting, out_rdy=1:
  - cycles 0-6: p0 granted.
  - cycle 7: guard, no grant.
  - cycles 8-14: p2 granted.
  - cycle 15: guard, no grant.
  - slot_domain toggles after cycles 7 and 15.
- tdm_en=1, p1 domain 1 requesting during slot_cnt=3 of domain 0 -> no grant until slot_cnt=0 of domain-1 slot, then grants=010.
- Async reset pulse at slot_cnt=5 of domain 1 while a grant is active -> outputs go idle immediately without waiting for a clock; after release, slot_cnt=0, slot_domain=0, prio=001.
